regfile_rename: RTL
===================

Name: regfile_rename

Overview:
- Architectural register file plus rename-status table, sitting directly downstream of the ROB commit port and beside Dispatch.
- Holds 32 x 32-bit committed values.
- For each register, holds a busy bit and the ROB tag of the youngest in-flight writer.
- Dispatch reads rs1/rs2 (value, or tag if busy) and claims rd for a new ROB entry. The ROB commit port writes results and releases tags. A ROB flush (clr) drops all pending renames.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired to zero).
- DATA_W, 32, register data width.
- ROB_W, 4, ROB tag width (16-entry ROB).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low stalls the rename update only
- clr  in  1  ROB flush pulse
- Dispatch_S  in  1  rename request valid
- Dispatch_rd  in  5  destination register to rename
- Dispatch_Reorder  in  ROB_W  ROB tag allocated to that destination
- Dispatch_rs1_S  in  1  rs1 lookup valid
- Dispatch_rs1  in  5  rs1 index
- Dispatch_rs1_busy  out  1  rs1 pending in ROB
- Dispatch_rs1_Reorder  out  ROB_W  producer tag when busy
- Dispatch_rs1_value  out  DATA_W  value when not busy
- Dispatch_rs2_S, Dispatch_rs2, Dispatch_rs2_busy, Dispatch_rs2_Reorder, Dispatch_rs2_value: same as the rs1 group
- Reg_write_S  in  1  ROB commit write valid
- Reg_rd  in  5  committed destination
- Reg_Reorder  in  ROB_W  committing ROB tag
- Reg_result  in  DATA_W  committed value

Behaviour:
- Reset is asynchronous. It forces value[i]=0, busy[i]=0 and tag[i]=0 for all i.
- While rst is high, all Dispatch_rs*_busy, _Reorder and _value outputs read 0.
- Read ports are combinational, zero latency. For each port:
  - If _S=0 or the index is 0: busy=0, value=0, Reorder=0.
  - Else if clr=1: busy=0, value = committed value with commit bypass applied.
  - Else if busy[r]=1, and Reg_write_S=1 with Reg_rd=r and Reg_Reorder=tag[r] in the same cycle: bypass, giving busy=0 and value=Reg_result.
  - Else if busy[r]=1: busy=1, Reorder=tag[r], value=0.
  - Else: busy=0, value=value[r], plus bypass when Reg_write_S=1 and Reg_rd=r.
- The read ports never see this cycle's Dispatch_rd rename. Dispatch orders sources before the destination.
- Commit, at posedge, independent of rdy:
  - If Reg_write_S=1 and Reg_rd!=0, then value[Reg_rd] <= Reg_result.
  - busy[Reg_rd] is cleared only if tag[Reg_rd]==Reg_Reorder and the same edge does not rename Reg_rd.
  - A stale tag leaves busy and tag unchanged.
- Rename, at posedge, only when rdy=1, clr=0, Dispatch_S=1 and Dispatch_rd!=0: busy[rd] <= 1 and tag[rd] <= Dispatch_Reorder.
- Rename and commit to the same rd on the same edge: the value is written, busy stays 1, and tag takes the new Dispatch_Reorder.
- clr=1 at posedge:
  - All busy bits are cleared and tags are left stale.
  - A commit on the same edge still writes its value (a JAL/JALR commit coincides with clr).
  - A rename on the same edge is dropped.
- rdy=0: renames are ignored. Commit and clr are still honored because they arrive as one-cycle pulses.
- Register x0 is never written or marked busy. Reads of x0 always return 0.
- There is no tag wrap handling beyond equality compare. ROB_W bits wrap naturally, and the ROB guarantees a tag is not reallocated while still live.

Decomposition:
- Shared include (Definition.v): RegBus, DataBus, ROBBus, Enable/Disable, True/False, Null, and the REG_NUM and ROB size constants.
- One natural sub-module, regfile_read_port, instantiated twice. It is pure combinational lookup plus commit bypass, taking the value/busy/tag vectors as inputs. Sequential state stays in regfile_rename.

Test Plan:
- Reset mid-run: after writes, pulse rst asynchronously between edges. Outputs go to 0 immediately. A read of x5 afterwards returns busy=0, value=0.
- Rename then commit: rename x3 to tag 7; next cycle the rs1=x3 read gives busy=1, Reorder=7. Commit x3/tag 7/0xDEADBEEF: in the same cycle the read gives busy=0, value 0xDEADBEEF. Next cycle busy=0, value 0xDEADBEEF.
- Stale commit: rename x4 to tag 2, then x4 to tag 9. Commit x4/tag 2/0x11: value becomes 0x11, busy stays 1, Reorder reads 9. Commit tag 9/0x22: busy=0, value 0x22.
- Same-edge rename and commit: x6 is busy with tag 1. Commit x6/tag 1/0x55 together with rename x6 to tag 3: afterwards busy=1, tag=3, value[6]=0x55.
- Flush: x1, x2 and x7 busy. clr together with commit x7/0xAB and rename x9 to tag 4: afterwards all busy bits are 0, x7=0xAB, x9 is not busy.
- x0 and rdy: rename x0 and commit x0/0xFF, and a read of x0 returns 0/not busy. With rdy=0, rename x8 is ignored while commit x10/0x33 still writes.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared definitions for the architectural register file / rename-status table.
package regfile_rename_pkg;

   // Architectural register index width (x0..x31).
   localparam int REG_W       = 5;
   localparam int REG_NUM_DEF = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int ROB_W_DEF   = 4;

   typedef logic [REG_W-1:0] reg_idx_t;

   // x0 is hardwired to zero: never written, never renamed, always reads 0.
   function automatic logic reg_is_x0(input reg_idx_t r);
      return (r == '0);
   endfunction

endpackage

// File: rtl/regfile_rename_read_port.sv
// One Dispatch source-operand lookup: returns the committed value, or the
// producer ROB tag when the register is still pending. A commit arriving in
// the same cycle is forwarded so Dispatch never misses a just-completed value.
module regfile_rename_read_port
   import regfile_rename_pkg::*;
#(
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROB_W   = ROB_W_DEF
) (
   input  logic                            rst,
   input  logic                            clr,
   input  logic                            rd_en_i,
   input  reg_idx_t                        rd_idx_i,
   input  logic [REG_NUM-1:0][DATA_W-1:0]  value_i,
   input  logic [REG_NUM-1:0]              busy_i,
   input  logic [REG_NUM-1:0][ROB_W-1:0]   tag_i,
   input  logic                            wr_s_i,
   input  reg_idx_t                        wr_rd_i,
   input  logic [ROB_W-1:0]                wr_tag_i,
   input  logic [DATA_W-1:0]               wr_data_i,
   output logic                            busy_o,
   output logic [ROB_W-1:0]                tag_o,
   output logic [DATA_W-1:0]               value_o
);

   logic                wr_hit;
   logic [DATA_W-1:0]   committed_val;

   assign wr_hit        = wr_s_i && (wr_rd_i == rd_idx_i);
   assign committed_val = wr_hit ? wr_data_i : value_i[rd_idx_i];

   // Priority: disabled/x0/reset -> flush -> pending producer -> committed value.
   always_comb begin
      busy_o  = 1'b0;
      tag_o   = '0;
      value_o = '0;
      if (rst || !rd_en_i || reg_is_x0(rd_idx_i)) begin
         value_o = '0;
      end else if (clr) begin
         // Flush cancels every in-flight producer; only committed state is valid.
         value_o = committed_val;
      end else if (busy_i[rd_idx_i]) begin
         if (wr_hit && (wr_tag_i == tag_i[rd_idx_i])) begin
            value_o = wr_data_i;
         end else begin
            busy_o = 1'b1;
            tag_o  = tag_i[rd_idx_i];
         end
      end else begin
         value_o = committed_val;
      end
   end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file plus rename-status table. Commit writes values
// and retires matching tags, Dispatch renames destinations, and a ROB flush
// drops every pending rename while keeping committed values.
module regfile_rename
   import regfile_rename_pkg::*;
#(
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROB_W   = ROB_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               clr,
   input  logic               Dispatch_S,
   input  reg_idx_t           Dispatch_rd,
   input  logic [ROB_W-1:0]   Dispatch_Reorder,
   input  logic               Dispatch_rs1_S,
   input  reg_idx_t           Dispatch_rs1,
   output logic               Dispatch_rs1_busy,
   output logic [ROB_W-1:0]   Dispatch_rs1_Reorder,
   output logic [DATA_W-1:0]  Dispatch_rs1_value,
   input  logic               Dispatch_rs2_S,
   input  reg_idx_t           Dispatch_rs2,
   output logic               Dispatch_rs2_busy,
   output logic [ROB_W-1:0]   Dispatch_rs2_Reorder,
   output logic [DATA_W-1:0]  Dispatch_rs2_value,
   input  logic               Reg_write_S,
   input  reg_idx_t           Reg_rd,
   input  logic [ROB_W-1:0]   Reg_Reorder,
   input  logic [DATA_W-1:0]  Reg_result
);

   logic [REG_NUM-1:0][DATA_W-1:0] value_q, value_d;
   logic [REG_NUM-1:0]             busy_q,  busy_d;
   logic [REG_NUM-1:0][ROB_W-1:0]  tag_q,   tag_d;

   logic rename_en;
   logic commit_en;

   // Renames stall on rdy and are dropped by a flush; commits are one-cycle
   // pulses from the ROB and must never be lost.
   assign rename_en = rdy && !clr && Dispatch_S && !reg_is_x0(Dispatch_rd);
   assign commit_en = Reg_write_S && !reg_is_x0(Reg_rd);

   // Next-state: commit first, then flush, then rename (later steps win).
   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;
      if (commit_en) begin
         value_d[Reg_rd] = Reg_result;
         // A stale tag means a younger writer still owns the register.
         if ((tag_q[Reg_rd] == Reg_Reorder) &&
             !(rename_en && (Dispatch_rd == Reg_rd))) begin
            busy_d[Reg_rd] = 1'b0;
         end
      end
      if (clr) begin
         // Tags are left stale on purpose; busy=0 makes them irrelevant.
         busy_d = '0;
      end
      if (rename_en) begin
         busy_d[Dispatch_rd] = 1'b1;
         tag_d[Dispatch_rd]  = Dispatch_Reorder;
      end
   end

   // State registers with asynchronous clear of values, busy bits and tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
         busy_q  <= '0;
         tag_q   <= '0;
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   regfile_rename_read_port #(
      .REG_NUM (REG_NUM),
      .DATA_W  (DATA_W),
      .ROB_W   (ROB_W)
   ) u_rs1 (
      .rst       (rst),
      .clr       (clr),
      .rd_en_i   (Dispatch_rs1_S),
      .rd_idx_i  (Dispatch_rs1),
      .value_i   (value_q),
      .busy_i    (busy_q),
      .tag_i     (tag_q),
      .wr_s_i    (Reg_write_S),
      .wr_rd_i   (Reg_rd),
      .wr_tag_i  (Reg_Reorder),
      .wr_data_i (Reg_result),
      .busy_o    (Dispatch_rs1_busy),
      .tag_o     (Dispatch_rs1_Reorder),
      .value_o   (Dispatch_rs1_value)
   );

   regfile_rename_read_port #(
      .REG_NUM (REG_NUM),
      .DATA_W  (DATA_W),
      .ROB_W   (ROB_W)
   ) u_rs2 (
      .rst       (rst),
      .clr       (clr),
      .rd_en_i   (Dispatch_rs2_S),
      .rd_idx_i  (Dispatch_rs2),
      .value_i   (value_q),
      .busy_i    (busy_q),
      .tag_i     (tag_q),
      .wr_s_i    (Reg_write_S),
      .wr_rd_i   (Reg_rd),
      .wr_tag_i  (Reg_Reorder),
      .wr_data_i (Reg_result),
      .busy_o    (Dispatch_rs2_busy),
      .tag_o     (Dispatch_rs2_Reorder),
      .value_o   (Dispatch_rs2_value)
   );

endmodule
